// File: rtl/toggle_cover_pkg.sv
// Shared types and sizing helpers for the toggle coverage feeder and sink.
// Imported by the detector and its popcount tree.
package toggle_cover_pkg;

  localparam int unsigned TCOV_WIDTH = 130;

  typedef enum logic {
    COVER_EVERY = 1'b0,
    COVER_FIRST = 1'b1
  } cover_mode_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/toggle_popcount.sv
// Combinational population count built as a recursive binary adder tree.
// Each node splits its input in half and sums the two sub-counts.
module toggle_popcount
  import toggle_cover_pkg::*;
#(
  parameter int unsigned WIDTH = TCOV_WIDTH
) (
  input  logic [WIDTH-1:0]            i_bits,
  output logic [cnt_width(WIDTH)-1:0] o_cnt
);

  if (WIDTH == 1) begin : g_leaf
    assign o_cnt = i_bits;
  end else begin : g_node
    localparam int unsigned OW = cnt_width(WIDTH);
    localparam int unsigned LW = WIDTH / 2;
    localparam int unsigned HW = WIDTH - LW;

    logic [cnt_width(LW)-1:0] w_lo;
    logic [cnt_width(HW)-1:0] w_hi;

    toggle_popcount #(
      .WIDTH(LW)
    ) u_lo (
      .i_bits(i_bits[LW-1:0]),
      .o_cnt (w_lo)
    );

    toggle_popcount #(
      .WIDTH(HW)
    ) u_hi (
      .i_bits(i_bits[WIDTH-1:LW]),
      .o_cnt (w_hi)
    );

    assign o_cnt = OW'(w_lo) + OW'(w_hi);
  end

endmodule

// File: rtl/toggle_cover_detector.sv
// Per-bit toggle detector feeding the toggle coverage sink.
// Emits registered cover pulses and tracks how many bits fully toggled.
module toggle_cover_detector
  import toggle_cover_pkg::*;
#(
  parameter int unsigned WIDTH = TCOV_WIDTH,
  parameter cover_mode_e MODE  = COVER_FIRST
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        clear,
  input  logic [WIDTH-1:0]            sig,
  output logic [WIDTH-1:0]            valid,
  output logic [cnt_width(WIDTH)-1:0] covered_cnt,
  output logic                        all_covered
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_rise_seen;
  logic [WIDTH-1:0] r_fall_seen;
  logic [WIDTH-1:0] r_done;
  logic [WIDTH-1:0] r_valid;
  logic [CW-1:0]    r_cnt;
  logic             r_all;
  logic             r_armed;

  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_rs_n;
  logic [WIDTH-1:0] w_fs_n;
  logic [WIDTH-1:0] w_new_done;
  logic [WIDTH-1:0] w_valid_nxt;
  logic [CW-1:0]    w_pop;
  logic [CW-1:0]    w_cnt_nxt;

  assign w_rise     = sig & ~r_prev;
  assign w_fall     = ~sig & r_prev;
  assign w_rs_n     = r_rise_seen | w_rise;
  assign w_fs_n     = r_fall_seen | w_fall;
  assign w_new_done = w_rs_n & w_fs_n & ~r_done;

  assign w_valid_nxt = (MODE == COVER_EVERY) ? (w_rise | w_fall)
                                             : w_new_done;

  // Only consumed on a live sampling cycle, so no gating needed here
  toggle_popcount #(
    .WIDTH(WIDTH)
  ) u_pop (
    .i_bits(w_new_done),
    .o_cnt (w_pop)
  );

  assign w_cnt_nxt = r_cnt + w_pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev      <= '0;
      r_rise_seen <= '0;
      r_fall_seen <= '0;
      r_done      <= '0;
      r_valid     <= '0;
      r_cnt       <= '0;
      r_all       <= 1'b0;
      r_armed     <= 1'b0;
    end else if (clear) begin
      r_rise_seen <= '0;
      r_fall_seen <= '0;
      r_done      <= '0;
      r_valid     <= '0;
      r_cnt       <= '0;
      r_all       <= 1'b0;
      r_armed     <= 1'b0;
    end else if (!en) begin
      r_valid <= '0;
      r_armed <= 1'b0;
    end else if (!r_armed) begin
      // Arming cycle: take a fresh baseline, never an edge
      r_prev  <= sig;
      r_valid <= '0;
      r_armed <= 1'b1;
    end else begin
      r_prev      <= sig;
      r_rise_seen <= w_rs_n;
      r_fall_seen <= w_fs_n;
      r_done      <= r_done | w_new_done;
      r_valid     <= w_valid_nxt;
      r_cnt       <= w_cnt_nxt;
      r_all       <= (w_cnt_nxt == CW'(WIDTH));
    end
  end

  assign valid       = r_valid;
  assign covered_cnt = r_cnt;
  assign all_covered = r_all;

  a_cnt_bound : assert property (
    @(posedge clock) disable iff (reset) r_cnt <= CW'(WIDTH)
  );

endmodule

// File: tb/tb_toggle_cover_detector.sv
// Directed bench for toggle_cover_detector in FIRST and EVERY modes.
// Both instances share stimulus; each test checks the relevant one.
module tb_toggle_cover_detector;
  import toggle_cover_pkg::*;

  localparam int unsigned W = 8;

  logic         clock;
  logic         reset;
  logic         en;
  logic         clear;
  logic [W-1:0] sig;

  logic [W-1:0] f_valid;
  logic [3:0]   f_cnt;
  logic         f_all;
  logic [W-1:0] e_valid;
  logic [3:0]   e_cnt;
  logic         e_all;

  int n_chk;
  int n_fail;

  toggle_cover_detector #(
    .WIDTH(W),
    .MODE (COVER_FIRST)
  ) u_first (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .clear      (clear),
    .sig        (sig),
    .valid      (f_valid),
    .covered_cnt(f_cnt),
    .all_covered(f_all)
  );

  toggle_cover_detector #(
    .WIDTH(W),
    .MODE (COVER_EVERY)
  ) u_every (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .clear      (clear),
    .sig        (sig),
    .valid      (e_valid),
    .covered_cnt(e_cnt),
    .all_covered(e_all)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL timeout: got no end, want $finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    clear = 1'b0;
    sig   = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    en     = 1'b0;
    clear  = 1'b0;
    sig    = 8'hFF;

    // reset release with a constant high input
    tick();
    tick();
    chk("rst_valid", 32'(f_valid), 32'h0);
    chk("rst_cnt", 32'(f_cnt), 32'h0);
    chk("rst_all", 32'(f_all), 32'h0);
    reset = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("nospur_valid", 32'(f_valid), 32'h0);
      chk("nospur_cnt", 32'(f_cnt), 32'h0);
    end

    // first-toggle on bit0
    do_reset();
    en  = 1'b1;
    sig = 8'h00;
    tick();
    sig = 8'h01;
    tick();
    chk("ft_rise_valid", 32'(f_valid), 32'h0);
    sig = 8'h00;
    tick();
    chk("ft_fall_valid", 32'(f_valid), 32'h01);
    chk("ft_fall_cnt", 32'(f_cnt), 32'h1);
    tick();
    chk("ft_one_cycle", 32'(f_valid), 32'h0);
    sig = 8'h01;
    tick();
    chk("ft_again_rise", 32'(f_valid), 32'h0);
    sig = 8'h00;
    tick();
    chk("ft_again_fall", 32'(f_valid), 32'h0);
    chk("ft_again_cnt", 32'(f_cnt), 32'h1);

    // EVERY mode and multi-bit completion in FIRST mode
    do_reset();
    en  = 1'b1;
    sig = 8'h00;
    tick();
    for (int i = 0; i < 4; i++) begin
      sig = (i % 2 == 0) ? 8'hFF : 8'h00;
      tick();
      chk("ev_valid", 32'(e_valid), 32'hFF);
      chk("ev_cnt", 32'(e_cnt), (i == 0) ? 32'h0 : 32'h8);
      chk("ev_all", 32'(e_all), (i == 0) ? 32'h0 : 32'h1);
      chk("mb_valid", 32'(f_valid), (i == 1) ? 32'hFF : 32'h0);
      chk("mb_cnt", 32'(f_cnt), (i == 0) ? 32'h0 : 32'h8);
      chk("mb_all", 32'(f_all), (i == 0) ? 32'h0 : 32'h1);
    end

    // clear after full coverage, then re-arm
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_cnt", 32'(f_cnt), 32'h0);
    chk("clr_all", 32'(f_all), 32'h0);
    chk("clr_valid", 32'(f_valid), 32'h0);
    sig = 8'h08;
    tick();
    chk("clr_arm_valid", 32'(f_valid), 32'h0);
    sig = 8'h00;
    tick();
    chk("clr_fall_valid", 32'(f_valid), 32'h0);
    sig = 8'h08;
    tick();
    chk("clr_b3_valid", 32'(f_valid), 32'h08);
    chk("clr_b3_cnt", 32'(f_cnt), 32'h1);

    // enable dropped while the input toggles
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sig = (i % 2 == 0) ? 8'h00 : 8'h08;
      tick();
      chk("en_off_valid", 32'(f_valid), 32'h0);
      chk("en_off_cnt", 32'(f_cnt), 32'h1);
    end
    en  = 1'b1;
    sig = 8'hFF;
    tick();
    chk("reen_arm_valid", 32'(f_valid), 32'h0);
    sig = 8'h00;
    tick();
    chk("reen_phantom", 32'(f_valid), 32'h0);
    chk("reen_cnt", 32'(f_cnt), 32'h1);

    // async reset while a pulse is on the output
    do_reset();
    en  = 1'b1;
    sig = 8'h00;
    tick();
    sig = 8'h01;
    tick();
    sig = 8'h00;
    tick();
    chk("ar_pre_valid", 32'(f_valid), 32'h01);
    chk("ar_pre_cnt", 32'(f_cnt), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(f_valid), 32'h0);
    chk("ar_cnt", 32'(f_cnt), 32'h0);
    chk("ar_all", 32'(f_all), 32'h0);
    chk("ar_ev_valid", 32'(e_valid), 32'h0);
    tick();
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/toggle_cover_detector.md
Name: toggle_cover_detector

Overview:
- Upstream feeder for the per-bit toggle coverage sink (GEN_w<N>_toggle).
- Samples a vector of monitored design signals every clock and detects per-bit rising and falling transitions.
- Tracks per-bit coverage and emits the one-cycle `valid` pulse vector that the sink consumes; also reports a covered-bit count and an all-covered flag.

Parameters:
- WIDTH, 130: number of monitored bits; must equal the sink's `valid` width.
- MODE, 1: 0 = EVERY (pulse on every edge of a bit); 1 = FIRST (pulse once, when a bit has seen both a rise and a fall since the last clear).

Ports:
- clock  in  1: sampling clock; same clock as the sink.
- reset  in  1: asynchronous, active-high reset.
- en  in  1: sampling enable.
- clear  in  1: synchronous re-arm of all coverage state.
- sig  in  WIDTH: monitored signals.
- valid  out  WIDTH: per-bit one-cycle cover pulses to the sink.
- covered_cnt  out  $clog2(WIDTH+1): number of bits fully toggled since the last clear.
- all_covered  out  1: high when covered_cnt == WIDTH.

Behaviour:
- Reset values (async reset asserted): prev, rise_seen, fall_seen, done, valid, covered_cnt, all_covered and armed are all 0.
- Arming:
  - armed clears whenever en=0 or clear=1.
  - The first clock with en=1 (and clear=0) loads prev<=sig and sets armed. No pulses are produced on that cycle.
  - No pulses are ever produced from the reset-time or pre-enable value of sig.
- Detection, evaluated each clock with en=1, armed=1 and clear=0:
  - rise = sig & ~prev
  - fall = ~sig & prev
  - prev <= sig
- State update with en=0: prev, the seen vectors and covered_cnt hold; valid <= 0.
- MODE=0 (EVERY):
  - valid <= rise | fall.
  - rise_seen / fall_seen / done still accumulate, so covered_cnt is meaningful in both modes.
- MODE=1 (FIRST):
  - rs_n = rise_seen | rise; fs_n = fall_seen | fall.
  - new_done = rs_n & fs_n & ~done.
  - valid <= new_done; done <= done | new_done.
  - Each bit pulses at most once per clear epoch.
- Latency: the pulse for an edge sampled at clock k appears at the output after clock k. The output is registered, so the sink sees it on clock k+1.
- Counting:
  - covered_cnt <= covered_cnt + popcount(new_done), in both modes.
  - The count cannot exceed WIDTH because done bits never re-count; no saturation logic is required, but the result must be asserted ≤ WIDTH.
  - all_covered is registered: all_covered <= (next covered_cnt == WIDTH). It updates in the same cycle as covered_cnt.
- Simultaneous rise and fall tracking:
  - A bit toggles at most once per sample, but it can complete done in the cycle its second edge type arrives.
  - Multiple bits completing in the same cycle all pulse together, and the count adds all of them.
- clear:
  - Takes priority over en.
  - Zeroes rise_seen, fall_seen, done, valid, covered_cnt, all_covered and armed.
  - prev is reloaded on the next arming cycle.
- Reset mid-operation: all state drops asynchronously; any in-flight valid pulse is lost (not replayed).
- Reset release: outputs stay 0 until the arming cycle plus a real edge.
- A bit that stays constant never pulses and never counts.

Decomposition:
- Shared package toggle_cover_pkg:
  - enum cover_mode_e {COVER_EVERY=0, COVER_FIRST=1}.
  - Function cnt_width(w) returning $clog2(w+1).
  - Default WIDTH constant shared with the sink generator.
- Sub-module toggle_popcount:
  - Parameterised WIDTH.
  - Purely combinational adder tree, out width cnt_width(WIDTH).
  - Used for the new_done count.

Test Plan:
- Reset-release no-spurious test:
  - Setup: WIDTH=8, MODE=1, reset high with sig=8'hFF; release reset; en=1; sig held at 8'hFF for 5 cycles.
  - Required: valid==0, covered_cnt==0 throughout.
- First-toggle test:
  - Setup: MODE=1; sig sequence 00→01→00 (bit0 rise then fall), with en high after arming.
  - Required: valid==8'h01 for exactly one cycle after the fall sample; covered_cnt==1.
  - Required: further toggles of bit0 produce no pulse.
- EVERY mode test:
  - Setup: MODE=0; sig alternates 00/FF for 4 samples after arming.
  - Required: valid==8'hFF on each of 4 consecutive cycles; covered_cnt==8; all_covered==1 after the second edge.
- Multi-bit completion test:
  - Setup: MODE=1; bits 0–7 rise together, then fall together.
  - Required: one cycle with valid==8'hFF; covered_cnt jumps 0→8 in that cycle; all_covered rises the same cycle.
- Clear and enable test:
  - Setup: after full coverage, pulse clear with en=1.
  - Required: next cycle covered_cnt==0, all_covered==0.
  - Required: an edge on the first cycle after clear does not pulse (arming cycle); a later rise+fall of bit3 gives valid==8'h08.
  - Setup: drop en for 3 cycles while sig toggles.
  - Required: no pulses, and no phantom edge on re-enable.
- Async reset mid-pulse test:
  - Setup: assert reset between clocks in the cycle valid==8'h01.
  - Required: valid, covered_cnt and all_covered go to 0 immediately without waiting for a clock edge.
